rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port between two producers.
- Producer 1: the pipeline writeback stage (WB). It has priority.
- Producer 2: the long-latency return path (AXI load return / mult-div unit). It uses valid/ready and is buffered in a 2-entry FIFO.
- The block also holds a busy scoreboard of registers with outstanding long-latency writes, used by the decode stage for hazard stalls.
- Its registered rf_* outputs drive the register file write port directly.

Parameters:
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2).
- MAX_WAIT, 4, consecutive cycles a non-empty FIFO may go without a pop before WB is force-stalled (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pipe_we  in  1  WB write request
- pipe_waddr  in  5  WB destination register
- pipe_wdata  in  32  WB data
- pipe_stall  out  1  WB must hold its request this cycle (combinational)
- lat_valid  in  1  long-latency result valid
- lat_ready  out  1  FIFO not full (combinational)
- lat_waddr  in  5  long-latency destination register
- lat_wdata  in  32  long-latency data
- iss_mark  in  1  a long-latency op issued this cycle
- iss_addr  in  5  its destination register
- rs_addr  in  5  decode source register 1
- rt_addr  in  5  decode source register 2
- rs_busy  out  1  rs_addr has an outstanding long-latency write
- rt_busy  out  1  rt_addr has an outstanding long-latency write
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  32  register file write data (registered)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: rf_we=0, rf_waddr=0, rf_wdata=0; FIFO empty; all dead flags clear; wait counter 0; scoreboard all 0.
  - Resulting outputs: lat_ready=1, pipe_stall=0.
  - Reset mid-operation discards buffered entries with no write performed.
- Push: lat_valid && lat_ready enqueues {addr, data, dead=0}.
  - lat_waddr==0 is accepted but enqueued already dead.
- Grant, evaluated each cycle:
  - force = FIFO non-empty && wait==MAX_WAIT.
  - If force: grant the FIFO head and assert pipe_stall. The WB request is ignored this cycle and must be re-presented.
  - Else if pipe_we && pipe_waddr!=0: grant WB.
  - Else if FIFO non-empty: grant the head.
  - pipe_we with pipe_waddr==0: no write, no stall, and a FIFO head may be granted that cycle.
- Granting the FIFO head pops it.
  - A live entry drives the rf_* registers with rf_we=1 on the next cycle (latency 1 from grant).
  - A dead entry is popped with rf_we=0.
- Wait counter:
  - Increments while the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- Ordering / kill:
  - When WB is granted with address X, every live FIFO entry with addr X is marked dead. WB is the younger producer, so its value wins.
  - An entry pushed in the same cycle as a WB grant to the same X is also marked dead.
- Scoreboard (32 bits):
  - iss_mark sets busy[iss_addr]; iss_addr==0 is ignored.
  - busy[a] clears when an entry with addr a is popped live or killed.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is always 0.
  - rs_busy / rt_busy are combinational reads of the registered scoreboard; there is no same-cycle bypass.
- Full FIFO: lat_ready=0. A pop and a push in the same cycle are allowed only when the FIFO is not full (no pass-through when full).

Optional Feature:
- Macro RF_ARB_STATS_EN.
- Defined: adds outputs stall_cnt[31:0] and kill_cnt[31:0].
  - stall_cnt counts pipe_stall cycles while pipe_we=1.
  - kill_cnt counts entries marked dead by a WB kill.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package rf_arb_pkg holds:
  - REG_AW=5 and DATA_W=32.
  - Entry struct {addr, data, dead}.
  - Function is_zero_reg.
- Sub-module rf_arb_fifo: DEPTH-entry circular FIFO with per-entry dead flags and a kill-by-address port.
- The top level holds the grant logic, wait counter, scoreboard and output registers.

Test Plan:
- WB only: pipe_we=1, addr=5, data=0xAAAA5555 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAAAA5555; pipe_stall=0.
- Priority and starvation: hold pipe_we=1 (addr 3) continuously and push one lat entry (addr 7, 0x11) → the entry waits 4 cycles; on the 5th cycle pipe_stall=1 and rf writes 7/0x11 on the following cycle; the wait counter returns to 0.
- Kill: iss_mark addr 9; push lat 9/0x22; WB write 9/0x33 granted → rf writes 9/0x33; the dead entry pops with rf_we=0; busy[9] clears; rs_busy(9)=0.
- Full: push 3 lat entries back-to-back with pipe_we=1 → lat_ready=0 on the third; that entry is accepted the cycle after the first pop.
- Register 0: pipe write to r0 and lat push to r0 → rf_we never 1 with addr 0; rs_busy(0)=0 after iss_mark addr 0.
- Reset mid-operation: 2 entries buffered and busy[4]=1, assert rst for one cycle → FIFO empty, busy all 0, rf_we=0 with no pending writes.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Optional statistics outputs are enabled by defining RF_ARB_STATS_EN.
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              dead;
    } entry_t;

    function automatic logic is_zero_reg(input logic [REG_AW-1:0] a);
        return (a == '0);
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Circular FIFO for long-latency register writes, with per-entry dead flags
// and a kill port that retires every live entry targeting a given register.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int KW    = $clog2(DEPTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  entry_t            push_entry,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_addr,
    output entry_t            head,
    output logic              empty,
    output logic              full,
    output logic [KW-1:0]     kill_num
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  dead_q, dead_d;
    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [REG_AW-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    assign empty = ~|valid_q;
    assign full  = &valid_q;
    assign head  = '{addr: addr_q[rd_ptr_q], data: data_q[rd_ptr_q], dead: dead_q[rd_ptr_q]};

    always_comb begin
        valid_d  = valid_q;
        dead_d   = dead_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        kill_num = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && valid_q[i] && !dead_q[i] && addr_q[i] == kill_addr) begin
                dead_d[i] = 1'b1;
                kill_num  = kill_num + KW'(1);
            end
        end

        if (pop && !empty) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + AW'(1);
        end

        // An entry arriving alongside a kill to its register is stale on arrival.
        if (push && !full) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_entry.addr;
            data_d[wr_ptr_q]  = push_entry.data;
            dead_d[wr_ptr_q]  = push_entry.dead;
            if (kill_en && !push_entry.dead && push_entry.addr == kill_addr) begin
                dead_d[wr_ptr_q] = 1'b1;
                kill_num         = kill_num + KW'(1);
            end
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            valid_q  <= '0;
            dead_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            dead_q   <= dead_d;
        end
    end

    // NOTE: payload storage is not reset; valid_q gates every use of it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the register-file write port between WB and the long-latency path,
// and tracks outstanding long-latency writes. Define RF_ARB_STATS_EN for counters.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    input  logic              lat_valid,
    output logic              lat_ready,
    input  logic [REG_AW-1:0] lat_waddr,
    input  logic [DATA_W-1:0] lat_wdata,
    input  logic              iss_mark,
    input  logic [REG_AW-1:0] iss_addr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef RF_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       kill_cnt
`endif
);

    localparam int         KW         = $clog2(DEPTH + 2);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    entry_t            head, push_entry;
    logic              fifo_empty, fifo_full;
    logic              push, pop, force_grant, wb_grant;
    logic [KW-1:0]     kill_num;

    logic [3:0]        wait_q, wait_d;
    logic [31:0]       busy_q, busy_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    assign lat_ready   = !fifo_full;
    assign push        = lat_valid && !fifo_full;
    assign push_entry  = '{addr: lat_waddr, data: lat_wdata, dead: is_zero_reg(lat_waddr)};

    // A starved FIFO head overrides WB, which must re-present its request.
    assign force_grant = !fifo_empty && (wait_q == MAX_WAIT_C);
    assign wb_grant    = !force_grant && pipe_we && !is_zero_reg(pipe_waddr);
    assign pop         = force_grant || (!wb_grant && !fifo_empty);
    assign pipe_stall  = force_grant;

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (wb_grant),
        .kill_addr  (pipe_waddr),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .kill_num   (kill_num)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_grant) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_wdata;
        end else if (pop && !head.dead) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head.addr;
            rf_wdata_d = head.data;
        end
    end

    always_comb begin
        if (fifo_empty || pop)
            wait_d = '0;
        else if (wait_q != MAX_WAIT_C)
            wait_d = wait_q + 4'd1;
        else
            wait_d = wait_q;
    end

    // Clears are applied before the set so an issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (pop && !head.dead)
            busy_d[head.addr] = 1'b0;
        if (kill_num != '0)
            busy_d[pipe_waddr] = 1'b0;
        if (iss_mark)
            busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign rs_busy  = busy_q[rs_addr];
    assign rt_busy  = busy_q[rt_addr];
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q     <= '0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef RF_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + ((pipe_stall && pipe_we) ? 32'd1 : 32'd0);
        kill_cnt_d  = kill_cnt_q + 32'(kill_num);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: expected register-file writes are queued
// as stimulus is driven and matched in order against every rf_we pulse.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_waddr;
    logic [31:0] lat_wdata;
    logic        iss_mark;
    logic [4:0]  iss_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef RF_ARB_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] kill_cnt;
`endif

    rf_wr_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .lat_valid  (lat_valid),
        .lat_ready  (lat_ready),
        .lat_waddr  (lat_waddr),
        .lat_wdata  (lat_wdata),
        .iss_mark   (iss_mark),
        .iss_addr   (iss_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef RF_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .kill_cnt   (kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [36:0] exp_q [$];
    logic [36:0] exp_w;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we    = 1'b0;
        pipe_waddr = '0;
        pipe_wdata = '0;
        lat_valid  = 1'b0;
        lat_waddr  = '0;
        lat_wdata  = '0;
        iss_mark   = 1'b0;
        iss_addr   = '0;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Every rf write must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("rf_we_unexpected", 64'(rf_we), 64'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("rf_write", 64'({rf_waddr, rf_wdata}), 64'(exp_w));
            end
        end
    end

    // WB held on r3 while one long-latency entry starves for MAX_WAIT cycles.
    task automatic starve(input logic [4:0] la, input logic [31:0] ld);
        pipe_we    = 1'b1;
        pipe_waddr = 5'd3;
        lat_valid  = 1'b1;
        lat_waddr  = la;
        lat_wdata  = ld;
        for (int c = 0; c <= 6; c++) begin
            pipe_wdata = 32'h3000_0000 + 32'(c);
            if (c == 1) lat_valid = 1'b0;
            #1;
            check("starve_stall", 64'(pipe_stall), 64'(c == 5));
            if (c == 5) expect_write(la, ld);
            else        expect_write(5'd3, pipe_wdata);
            tick();
        end
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_rf_we",      64'(rf_we),      64'd0);
        check("reset_rf_waddr",   64'(rf_waddr),   64'd0);
        check("reset_rf_wdata",   64'(rf_wdata),   64'd0);
        check("reset_lat_ready",  64'(lat_ready),  64'd1);
        check("reset_pipe_stall", 64'(pipe_stall), 64'd0);

        // WB only.
        pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hAAAA_5555;
        expect_write(5'd5, 32'hAAAA_5555);
        #1 check("wb_only_stall", 64'(pipe_stall), 64'd0);
        tick();
        idle();
        tick();

        // Starvation twice: the second run shows the wait counter restarted at 0.
        starve(5'd7, 32'h11);
        tick();
        starve(5'd6, 32'h66);
        tick();

        // Kill of a stored entry by a younger WB write.
        iss_mark = 1'b1; iss_addr = 5'd9;
        tick();
        idle(); rs_addr = 5'd9;
        #1 check("kill_busy_set", 64'(rs_busy), 64'd1);
        pipe_we = 1'b1; pipe_waddr = 5'd8; pipe_wdata = 32'h88;
        lat_valid = 1'b1; lat_waddr = 5'd9; lat_wdata = 32'h22;
        expect_write(5'd8, 32'h88);
        tick();
        idle();
        pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h33;
        expect_write(5'd9, 32'h33);
        #1 check("kill_busy_held", 64'(rs_busy), 64'd1);
        tick();
        idle();
        #1 check("kill_busy_clr", 64'(rs_busy), 64'd0);
        tick();
        tick();

        // Kill of an entry pushed in the same cycle as the WB grant.
        iss_mark = 1'b1; iss_addr = 5'd10;
        tick();
        idle(); rt_addr = 5'd10;
        #1 check("kill_same_busy_set", 64'(rt_busy), 64'd1);
        pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'h55;
        lat_valid = 1'b1; lat_waddr = 5'd10; lat_wdata = 32'h44;
        expect_write(5'd10, 32'h55);
        tick();
        idle();
        #1 check("kill_same_busy_clr", 64'(rt_busy), 64'd0);
        tick();
        tick();

        // Full FIFO under continuous WB traffic.
        for (int c = 0; c <= 6; c++) begin
            pipe_we    = 1'b1;
            pipe_waddr = 5'd2;
            pipe_wdata = 32'h2000_0000 + 32'(c);
            lat_valid  = 1'b1;
            lat_waddr  = (c == 0) ? 5'd11 : (c == 1) ? 5'd12 : 5'd13;
            lat_wdata  = (c == 0) ? 32'hB1 : (c == 1) ? 32'hB2 : 32'hB3;
            #1;
            check("full_ready", 64'(lat_ready), 64'(c < 2 || c == 6));
            check("full_stall", 64'(pipe_stall), 64'(c == 5));
            if (c == 5) expect_write(5'd11, 32'hB1);
            else        expect_write(5'd2, pipe_wdata);
            tick();
        end
        idle();
        expect_write(5'd12, 32'hB2);
        expect_write(5'd13, 32'hB3);
        tick();
        tick();
        #1 check("full_drained_ready", 64'(lat_ready), 64'd1);
        tick();

        // Register 0 is never written or marked busy.
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
        lat_valid = 1'b1; lat_waddr = 5'd0; lat_wdata = 32'hBEEF;
        iss_mark = 1'b1; iss_addr = 5'd0; rs_addr = 5'd0;
        #1 check("r0_stall", 64'(pipe_stall), 64'd0);
        tick();
        idle();
        #1 check("r0_busy", 64'(rs_busy), 64'd0);
        tick();
        tick();

        // WB to r0 leaves the port free for the FIFO head.
        pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h4444;
        lat_valid = 1'b1; lat_waddr = 5'd14; lat_wdata = 32'hE0;
        expect_write(5'd4, 32'h4444);
        tick();
        lat_valid = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'h0BAD;
        expect_write(5'd14, 32'hE0);
        #1 check("r0_head_stall", 64'(pipe_stall), 64'd0);
        tick();
        idle();
        tick();

        // Reset mid-operation discards the buffered entries.
        iss_mark = 1'b1; iss_addr = 5'd4;
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1000;
        lat_valid = 1'b1; lat_waddr = 5'd4; lat_wdata = 32'h41;
        expect_write(5'd1, 32'h1000);
        tick();
        iss_mark = 1'b0; pipe_wdata = 32'h1001;
        lat_waddr = 5'd15; lat_wdata = 32'h51;
        expect_write(5'd1, 32'h1001);
        tick();
        idle(); rs_addr = 5'd4;
        #1;
        check("rst_pre_busy",  64'(rs_busy),   64'd1);
        check("rst_pre_ready", 64'(lat_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(lat_ready),  64'd1);
        check("rst_busy",  64'(rs_busy),    64'd0);
        check("rst_rf_we", 64'(rf_we),      64'd0);
        check("rst_stall", 64'(pipe_stall), 64'd0);
        for (int i = 0; i < 4; i++) tick();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
